ahfp_add_pipe: RTL

Pipelined, parametrised IEEE-754-style floating-point adder/subtractor, the multi-cycle successor to the team's combinational single-precision adder. It handles full signed addition and subtraction with cancellation, round-to-nearest-even, and infinity/NaN handling, and it accepts one operation per cycle. It sits behind the processor's multi-cycle custom-instruction port (clk_en/start/done) and is generic in exponent and mantissa width.

---
 rtl/ahfp_add_pipe_if.sv | 27 ++
 rtl/ahfp_add_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ahfp_add_pipe_if.sv
// Handshake/data bundle for ahfp_add_pipe: request side (clk_en, start, n, dataa, datab)
// and completion side (result, done). The master drives requests, the slave returns results.
// Word width W = 1 + EXP_W + MAN_W.
interface ahfp_add_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic          clk_en;   // pipeline advance enable
   logic          start;    // operation request
   logic          n;        // 0: a+b, 1: a-b
   logic [W-1:0]  dataa;    // operand A
   logic [W-1:0]  datab;    // operand B
   logic [W-1:0]  result;   // registered result
   logic          done;     // completion pulse

   modport master (
      output clk_en, start, n, dataa, datab,
      input  result, done
   );

   modport slave (
      input  clk_en, start, n, dataa, datab,
      output result, done
   );
endinterface

// File: rtl/ahfp_add_pipe.sv
// Purpose: pipelined floating-point add/subtract (flush-to-zero, RNE, inf/NaN handling).
// Latency: 4 enabled cycles, one new operation accepted every enabled cycle.
// Backpressure: none beyond clk_en; clk_en low freezes every stage including done/result.
// Ports: clk, reset_n (async active-low); bus (slave modport) carries clk_en, start, n,
//        dataa, datab in and result, done out.
module ahfp_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic            clk,
   input  logic            reset_n,
   ahfp_add_pipe_if.slave  bus
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int F   = MAN_W + 4;          // hidden, mantissa, guard, round, sticky
   localparam int S   = MAN_W + 5;          // sum with carry-out
   localparam int EW  = EXP_W + 2;          // signed exponent working width
   localparam int LZW = $clog2(F + 1);
   localparam logic [W-1:0]  QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [EW-1:0] E_INF = {2'b00, {EXP_W{1'b1}}};

   // ---------------- stage 1: unpack, classify, order by magnitude ----------------
   logic             sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_ge_b;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W:0]   ma, mb;

   logic             s1_spec_d;
   logic [W-1:0]     s1_spec_res_d;
   logic             s1_sx_d, s1_sy_d;
   logic [EXP_W-1:0] s1_ex_d, s1_d_d;
   logic [MAN_W:0]   s1_mx_d, s1_my_d;

   logic             s1_vld_q, s1_spec_q, s1_sx_q, s1_sy_q;
   logic [W-1:0]     s1_spec_res_q;
   logic [EXP_W-1:0] s1_ex_q, s1_d_q;
   logic [MAN_W:0]   s1_mx_q, s1_my_q;

   always_comb begin
      sa     = bus.dataa[W-1];
      sb     = bus.datab[W-1] ^ bus.n;     // subtract = add with B negated
      ea     = bus.dataa[W-2 -: EXP_W];
      eb     = bus.datab[W-2 -: EXP_W];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_nan  = (ea == '1) && (bus.dataa[MAN_W-1:0] != '0);
      b_nan  = (eb == '1) && (bus.datab[MAN_W-1:0] != '0);
      a_inf  = (ea == '1) && (bus.dataa[MAN_W-1:0] == '0);
      b_inf  = (eb == '1) && (bus.datab[MAN_W-1:0] == '0);
      // Denormals are flushed: a zero exponent forces the whole significand to zero.
      ma     = a_zero ? '0 : {1'b1, bus.dataa[MAN_W-1:0]};
      mb     = b_zero ? '0 : {1'b1, bus.datab[MAN_W-1:0]};
      a_ge_b = {ea, ma} >= {eb, mb};

      s1_spec_d     = 1'b1;
      s1_spec_res_d = '0;
      if (a_nan || b_nan)         s1_spec_res_d = QNAN;
      else if (a_inf && b_inf)    s1_spec_res_d = (sa == sb) ? {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : QNAN;
      else if (a_inf)             s1_spec_res_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (b_inf)             s1_spec_res_d = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (a_zero && b_zero)  s1_spec_res_d = {sa & sb, {(W-1){1'b0}}};
      else                        s1_spec_d     = 1'b0;

      s1_sx_d = a_ge_b ? sa : sb;
      s1_sy_d = a_ge_b ? sb : sa;
      s1_ex_d = a_ge_b ? ea : eb;
      s1_mx_d = a_ge_b ? ma : mb;
      s1_my_d = a_ge_b ? mb : ma;
      s1_d_d  = a_ge_b ? (ea - eb) : (eb - ea);
   end

   // ---------------- stage 2: align Y onto X's exponent ----------------
   logic [2*F-1:0]   y_wide;
   logic [F-1:0]     s2_my_d;

   logic             s2_vld_q, s2_spec_q, s2_sign_q, s2_sub_q;
   logic [W-1:0]     s2_spec_res_q;
   logic [EXP_W-1:0] s2_ex_q;
   logic [F-1:0]     s2_mx_q, s2_my_q;

   always_comb begin
      // Lower half catches every bit shifted out; it folds into sticky.
      y_wide = {s1_my_q, 3'b000, {F{1'b0}}} >> s1_d_q;
      if (32'(s1_d_q) >= 32'(MAN_W + 3))
         s2_my_d = {{(F-1){1'b0}}, |s1_my_q};
      else
         s2_my_d = {y_wide[2*F-1:F+1], y_wide[F] | (|y_wide[F-1:0])};
   end

   // ---------------- stage 3: add/subtract magnitudes, count leading zeros ----------------
   logic [S-1:0]     s3_sum_d;
   logic [LZW-1:0]   s3_lzc_d;
   logic             lz_found;

   logic             s3_vld_q, s3_spec_q, s3_sign_q;
   logic [W-1:0]     s3_spec_res_q;
   logic [EXP_W-1:0] s3_ex_q;
   logic [S-1:0]     s3_sum_q;
   logic [LZW-1:0]   s3_lzc_q;

   always_comb begin
      // X >= Y in magnitude, so the difference never goes negative.
      s3_sum_d = s2_sub_q ? ({1'b0, s2_mx_q} - {1'b0, s2_my_q})
                          : ({1'b0, s2_mx_q} + {1'b0, s2_my_q});
      s3_lzc_d = LZW'(F);
      lz_found = 1'b0;
      for (int i = F - 1; i >= 0; i--) begin
         if (!lz_found && s3_sum_d[i]) begin
            s3_lzc_d = LZW'(F - 1 - i);
            lz_found = 1'b1;
         end
      end
   end

   // ---------------- stage 4: normalise, round to nearest even, pack ----------------
   logic [F-1:0]     norm;
   logic [EW-1:0]    e_n, e_r;
   logic             rnd_up;
   logic [MAN_W+1:0] mant_r;
   logic [MAN_W-1:0] man_f;
   logic [W-1:0]     res_d;

   logic             done_q;
   logic [W-1:0]     result_q;

   always_comb begin
      if (s3_sum_q[S-1]) begin
         norm = {s3_sum_q[S-1:2], |s3_sum_q[1:0]};
         e_n  = {2'b00, s3_ex_q} + EW'(1);
      end else begin
         norm = s3_sum_q[F-1:0] << s3_lzc_q;
         e_n  = {2'b00, s3_ex_q} - EW'(s3_lzc_q);
      end
      rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r = {1'b0, norm[F-1:3]} + (MAN_W+2)'(rnd_up);
      e_r    = e_n;
      man_f  = mant_r[MAN_W-1:0];
      if (mant_r[MAN_W+1]) begin
         e_r   = e_n + EW'(1);
         man_f = mant_r[MAN_W:1];
      end

      if (s3_spec_q)                              res_d = s3_spec_res_q;
      else if (s3_sum_q == '0)                    res_d = '0;
      else if (e_r[EW-1] || (e_r == '0))          res_d = {s3_sign_q, {(W-1){1'b0}}};
      else if ($signed(e_r) >= $signed(E_INF))    res_d = {s3_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else                                        res_d = {s3_sign_q, e_r[EXP_W-1:0], man_f};
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld_q <= 1'b0;  s1_spec_q <= 1'b0;  s1_spec_res_q <= '0;
         s1_sx_q  <= 1'b0;  s1_sy_q   <= 1'b0;  s1_ex_q <= '0;  s1_d_q <= '0;
         s1_mx_q  <= '0;    s1_my_q   <= '0;
         s2_vld_q <= 1'b0;  s2_spec_q <= 1'b0;  s2_spec_res_q <= '0;
         s2_sign_q <= 1'b0; s2_sub_q  <= 1'b0;  s2_ex_q <= '0;
         s2_mx_q  <= '0;    s2_my_q   <= '0;
         s3_vld_q <= 1'b0;  s3_spec_q <= 1'b0;  s3_spec_res_q <= '0;
         s3_sign_q <= 1'b0; s3_ex_q   <= '0;    s3_sum_q <= '0;  s3_lzc_q <= '0;
         done_q   <= 1'b0;  result_q  <= '0;
      end else if (bus.clk_en) begin
         s1_vld_q      <= bus.start;
         s1_spec_q     <= s1_spec_d;
         s1_spec_res_q <= s1_spec_res_d;
         s1_sx_q       <= s1_sx_d;
         s1_sy_q       <= s1_sy_d;
         s1_ex_q       <= s1_ex_d;
         s1_d_q        <= s1_d_d;
         s1_mx_q       <= s1_mx_d;
         s1_my_q       <= s1_my_d;

         s2_vld_q      <= s1_vld_q;
         s2_spec_q     <= s1_spec_q;
         s2_spec_res_q <= s1_spec_res_q;
         s2_sign_q     <= s1_sx_q;
         s2_sub_q      <= s1_sx_q ^ s1_sy_q;
         s2_ex_q       <= s1_ex_q;
         s2_mx_q       <= {s1_mx_q, 3'b000};
         s2_my_q       <= s2_my_d;

         s3_vld_q      <= s2_vld_q;
         s3_spec_q     <= s2_spec_q;
         s3_spec_res_q <= s2_spec_res_q;
         s3_sign_q     <= s2_sign_q;
         s3_ex_q       <= s2_ex_q;
         s3_sum_q      <= s3_sum_d;
         s3_lzc_q      <= s3_lzc_d;

         done_q        <= s3_vld_q;
         if (s3_vld_q) result_q <= res_d;
      end
   end

   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule
